// File: rtl/pic_inta_sequencer.sv
// 8259A interrupt-acknowledge initiator: two INTA_n pulses, vector capture, valid/ready handoff.
// Optional automatic non-specific EOI write after handoff: define PIC_INTA_AUTO_EOI_WRITE_EN.
module pic_inta_sequencer #(
  parameter int INTA_LOW_CYCLES = 2,
  parameter int INTA_GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       INT,
  input  logic       int_enable,
  input  logic [7:0] data_bus_in,
  output logic       INTA_n,
  output logic [7:0] vector,
  output logic       vector_valid,
  input  logic       vector_ready,
  output logic       busy,
  output logic       wr_n,
  output logic       a0,
  output logic [7:0] data_out,
  output logic       data_out_en
);

  // state    | meaning
  // IDLE     | waiting for INT while int_enable is high
  // PULSE1   | first INTA_n low pulse
  // GAP      | INTA_n high between pulses
  // PULSE2   | second INTA_n low pulse, PIC drives the vector
  // HANDOFF  | vector captured on entry cycle, then held valid until ready
  // EOI      | OCW2 non-specific EOI write strobe (optional)
  // EOI_HOLD | data held one cycle after wr_n rises (optional)
`ifdef PIC_INTA_AUTO_EOI_WRITE_EN
  typedef enum logic [2:0] {IDLE, PULSE1, GAP, PULSE2, HANDOFF, EOI, EOI_HOLD} state_t;
`else
  typedef enum logic [2:0] {IDLE, PULSE1, GAP, PULSE2, HANDOFF} state_t;
`endif

  localparam logic [3:0] LOW_LOAD = 4'(INTA_LOW_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD = 4'(INTA_GAP_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;

  assign busy = (state != IDLE);

  // Outputs follow the state by one register stage, so INTA_n falls one cycle
  // after INT is sampled and is still low on the edge that captures the vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      INTA_n       <= 1'b1;
      vector       <= 8'h00;
      vector_valid <= 1'b0;
    end else begin
      INTA_n <= !((state == PULSE1) || (state == PULSE2));
      case (state)
        IDLE: begin
          if (INT && int_enable) begin
            state <= PULSE1;
            cnt   <= LOW_LOAD;
          end
        end
        PULSE1: begin
          if (cnt == 4'd0) begin
            state <= GAP;
            cnt   <= GAP_LOAD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        GAP: begin
          if (cnt == 4'd0) begin
            state <= PULSE2;
            cnt   <= LOW_LOAD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        PULSE2: begin
          if (cnt == 4'd0) begin
            state <= HANDOFF;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HANDOFF: begin
          if (!vector_valid) begin
            vector       <= data_bus_in;
            vector_valid <= 1'b1;
          end else if (vector_ready) begin
            vector_valid <= 1'b0;
`ifdef PIC_INTA_AUTO_EOI_WRITE_EN
            state <= EOI;
            cnt   <= LOW_LOAD;
`else
            state <= IDLE;
`endif
          end
        end
`ifdef PIC_INTA_AUTO_EOI_WRITE_EN
        EOI: begin
          if (cnt == 4'd0) begin
            state <= EOI_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        EOI_HOLD: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIC_INTA_AUTO_EOI_WRITE_EN
  assign a0 = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_n        <= 1'b1;
      data_out    <= 8'h00;
      data_out_en <= 1'b0;
    end else begin
      wr_n        <= (state != EOI);
      data_out_en <= (state == EOI) || (state == EOI_HOLD);
      data_out    <= ((state == EOI) || (state == EOI_HOLD)) ? 8'h20 : 8'h00;
    end
  end
`else
  assign wr_n        = 1'b1;
  assign a0          = 1'b0;
  assign data_out    = 8'h00;
  assign data_out_en = 1'b0;
`endif

endmodule
